// File: rtl/ohlcv_row_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : ohlcv_row_reader_if
// Description : Bundle of the OHLCV row reader's control, storage-address,
//               storage-data and record-handshake signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface ohlcv_row_reader_if #(
  parameter int ROW_W = 10
);
  logic             start;
  logic             abort;
  logic [ROW_W-1:0] first_row;
  logic [ROW_W-1:0] last_row;
  logic [ROW_W-1:0] row_index;
  logic [2:0]       col_index;
  logic [31:0]      mem_data;
  logic             busy;
  logic             done;
  logic             rec_valid;
  logic             rec_ready;
  logic [ROW_W-1:0] rec_row;
  logic [31:0]      rec_timestamp;
  logic [31:0]      rec_open;
  logic [31:0]      rec_high;
  logic [31:0]      rec_low;
  logic [31:0]      rec_close;
  logic [31:0]      rec_volume;
  logic             rec_last;

  // Controller / storage / consumer side
  modport master (
    output start, abort, first_row, last_row, mem_data, rec_ready,
    input  row_index, col_index, busy, done, rec_valid, rec_row,
           rec_timestamp, rec_open, rec_high, rec_low, rec_close,
           rec_volume, rec_last
  );

  // Row reader side
  modport slave (
    input  start, abort, first_row, last_row, mem_data, rec_ready,
    output row_index, col_index, busy, done, rec_valid, rec_row,
           rec_timestamp, rec_open, rec_high, rec_low, rec_close,
           rec_volume, rec_last
  );
endinterface
`default_nettype wire

// File: rtl/ohlcv_row_reader.sv
`default_nettype none
// ============================================================================
// Module      : ohlcv_row_reader
// Description : Walks a row range of the market-data store, reads the six
//               words of each row column by column and presents each row as
//               one record on a valid/ready handshake. Words pass through raw.
// Revision    : 1.0 - initial release
// ============================================================================
module ohlcv_row_reader #(
  parameter int NUM_ROWS = 1024,
  parameter int ROW_W    = 10,
  parameter int NUM_COLS = 6,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  ohlcv_row_reader_if.slave bus
);

  localparam logic [2:0] c_col_last = 3'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_index_q, row_index_d;
  logic [ROW_W-1:0] last_row_q, last_row_d;
  logic [ROW_W-1:0] rec_row_q, rec_row_d;
  logic [2:0]       col_index_q, col_index_d;
  logic             issued_all_q, issued_all_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rec_valid_q, rec_valid_d;
  logic             rec_last_q, rec_last_d;
  logic [31:0]      data_q [NUM_COLS];
  logic [31:0]      data_d [NUM_COLS];
  logic             tag_vld_q [RD_LAT];
  logic             tag_vld_d [RD_LAT];
  logic [2:0]       tag_col_q [RD_LAT];
  logic [2:0]       tag_col_d [RD_LAT];

  logic [ROW_W-1:0] last_lim;
  logic             issue;
  logic             cap_vld;
  logic [2:0]       cap_col;

  // A requested last row beyond the populated store is pulled back to the
  // final row so the row counter can never address past the end.
  generate
    if (NUM_ROWS < (1 << ROW_W)) begin : g_clamp
      localparam logic [ROW_W-1:0] c_row_max = ROW_W'(NUM_ROWS - 1);
      assign last_lim = (bus.last_row > c_row_max) ? c_row_max : bus.last_row;
    end else begin : g_full
      assign last_lim = bus.last_row;
    end
  endgenerate

  // Next-state logic: range capture, column issue, tag-driven capture,
  // record handshake and abort override.
  always_comb begin
    state_d      = state_q;
    row_index_d  = row_index_q;
    last_row_d   = last_row_q;
    rec_row_d    = rec_row_q;
    col_index_d  = col_index_q;
    issued_all_d = issued_all_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rec_valid_d  = rec_valid_q;
    rec_last_d   = rec_last_q;
    data_d       = data_q;

    // A column is issued on every FETCH cycle until the last one has gone out;
    // the tag line follows the data through the storage read latency.
    issue        = (state_q == ST_FETCH) && !issued_all_q;
    tag_vld_d[0] = issue;
    tag_col_d[0] = col_index_q;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_col_d[i] = tag_col_q[i-1];
    end
    cap_vld = tag_vld_q[RD_LAT-1];
    cap_col = tag_col_q[RD_LAT-1];

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.first_row <= last_lim) begin
            last_row_d   = last_lim;
            row_index_d  = bus.first_row;
            col_index_d  = 3'd0;
            issued_all_d = 1'b0;
            busy_d       = 1'b1;
            state_d      = ST_FETCH;
          end else begin
            // Empty range: finish immediately without becoming busy.
            done_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (issue) begin
          if (col_index_q == c_col_last) begin
            issued_all_d = 1'b1;
          end else begin
            col_index_d = col_index_q + 3'd1;
          end
        end
        if (cap_vld) begin
          data_d[cap_col] = bus.mem_data;
          if (cap_col == c_col_last) begin
            rec_valid_d = 1'b1;
            rec_row_d   = row_index_q;
            rec_last_d  = (row_index_q == last_row_q);
            state_d     = ST_PRESENT;
          end
        end
      end
      ST_PRESENT: begin
        if (bus.rec_ready) begin
          rec_valid_d = 1'b0;
          if (rec_last_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            row_index_d  = row_index_q + 1'b1;
            col_index_d  = 3'd0;
            issued_all_d = 1'b0;
            state_d      = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything but reset and leaves no trace of the scan.
    if (bus.abort) begin
      state_d      = ST_IDLE;
      row_index_d  = '0;
      last_row_d   = '0;
      rec_row_d    = '0;
      col_index_d  = 3'd0;
      issued_all_d = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      rec_valid_d  = 1'b0;
      rec_last_d   = 1'b0;
      for (int i = 0; i < NUM_COLS; i++) data_d[i] = '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_vld_d[i] = 1'b0;
        tag_col_d[i] = 3'd0;
      end
    end
  end

  // State register: every output and pipeline stage is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      row_index_q  <= '0;
      last_row_q   <= '0;
      rec_row_q    <= '0;
      col_index_q  <= 3'd0;
      issued_all_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rec_valid_q  <= 1'b0;
      rec_last_q   <= 1'b0;
      for (int i = 0; i < NUM_COLS; i++) data_q[i] <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_col_q[i] <= 3'd0;
      end
    end else begin
      state_q      <= state_d;
      row_index_q  <= row_index_d;
      last_row_q   <= last_row_d;
      rec_row_q    <= rec_row_d;
      col_index_q  <= col_index_d;
      issued_all_q <= issued_all_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rec_valid_q  <= rec_valid_d;
      rec_last_q   <= rec_last_d;
      for (int i = 0; i < NUM_COLS; i++) data_q[i] <= data_d[i];
      for (int i = 0; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_d[i];
        tag_col_q[i] <= tag_col_d[i];
      end
    end
  end

  assign bus.row_index     = row_index_q;
  assign bus.col_index     = col_index_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.rec_valid     = rec_valid_q;
  assign bus.rec_row       = rec_row_q;
  assign bus.rec_last      = rec_last_q;
  assign bus.rec_timestamp = data_q[0];
  assign bus.rec_open      = data_q[1];
  assign bus.rec_high      = data_q[2];
  assign bus.rec_low       = data_q[3];
  assign bus.rec_close     = data_q[4];
  assign bus.rec_volume    = data_q[5];

endmodule
`default_nettype wire

// File: tb/tb_ohlcv_row_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ohlcv_row_reader
// Description : Scoreboard bench for ohlcv_row_reader: directed and random
//               scans against a queue of expected records and a cycle-level
//               timing model; a second instance runs with two-cycle storage.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ohlcv_row_reader;

  localparam int NUM_ROWS = 1024;
  localparam int ROW_W    = 10;
  localparam int NUM_COLS = 6;
  localparam int LAT1     = NUM_COLS + 1 + 1;

  typedef struct {
    int           row;
    bit           last;
    logic [191:0] data;
  } rec_t;

  typedef struct {
    string        name;
    logic [191:0] act;
    logic [191:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ohlcv_row_reader_if #(.ROW_W(ROW_W)) if1 ();
  ohlcv_row_reader_if #(.ROW_W(ROW_W)) if2 ();

  ohlcv_row_reader #(.NUM_ROWS(NUM_ROWS), .ROW_W(ROW_W), .NUM_COLS(NUM_COLS), .RD_LAT(1))
    dut1 (.clk(clk), .reset(rst), .bus(if1.slave));
  ohlcv_row_reader #(.NUM_ROWS(NUM_ROWS), .ROW_W(ROW_W), .NUM_COLS(NUM_COLS), .RD_LAT(2))
    dut2 (.clk(clk), .reset(rst), .bus(if2.slave));

  // Storage model: address seen in cycle k is answered RD_LAT cycles later
  logic [31:0]      mem [NUM_ROWS][NUM_COLS];
  logic [ROW_W-1:0] a1_row, a2a_row, a2b_row;
  logic [2:0]       a1_col, a2a_col, a2b_col;
  always @(posedge clk) begin
    a1_row  <= if1.row_index;  a1_col  <= if1.col_index;
    a2a_row <= if2.row_index;  a2a_col <= if2.col_index;
    a2b_row <= a2a_row;        a2b_col <= a2a_col;
  end
  assign if1.mem_data = (int'(a1_col) < NUM_COLS) ? mem[a1_row][int'(a1_col)] : 32'h0;
  assign if2.mem_data = (int'(a2b_col) < NUM_COLS) ? mem[a2b_row][int'(a2b_col)] : 32'h0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rec_t exp_q [$];
  chk_t chk_q [$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic cmp(input string nm, input logic [191:0] a, input logic [191:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, a, e);
    end
  endtask

  // ---------------- monitor / scoreboard (sole owner of the counters) -------
  int   m_row, m_last, fs, exp_rise, exp_done, exp_clear, c, d;
  bit   m_busy, m_pres;
  rec_t cur;
  chk_t k;

  initial begin
    m_busy = 0; m_pres = 0; m_row = 0; m_last = 0; fs = 0;
    exp_rise = -1; exp_done = -1; exp_clear = -1;
    forever begin
      @(negedge clk);
      c = cyc;
      while (chk_q.size() > 0) begin
        k = chk_q.pop_front();
        cmp(k.name, k.act, k.exp);
      end
      if (rst) begin
        m_busy = 0; m_pres = 0; exp_rise = -1; exp_done = -1; exp_clear = -1;
        continue;
      end

      if (c == exp_done) begin
        cmp("done pulse", 192'(if1.done), 192'(1));
        cmp("busy low at done", 192'(if1.busy), 192'(0));
        exp_done = -1;
      end else begin
        cmp("no done", 192'(if1.done), 192'(0));
      end

      if (c == exp_clear) begin
        cmp("abort busy", 192'(if1.busy), 192'(0));
        cmp("abort rec_valid", 192'(if1.rec_valid), 192'(0));
        cmp("abort row_index", 192'(if1.row_index), 192'(0));
        cmp("abort col_index", 192'(if1.col_index), 192'(0));
        exp_clear = -1;
      end

      cmp("busy", 192'(if1.busy), 192'(m_busy));
      cmp("done/rec_valid exclusive", 192'(if1.done && if1.rec_valid), 192'(0));

      if (c == exp_rise) begin
        cmp("rec_valid rise time", 192'(if1.rec_valid), 192'(1));
        cmp("record queued", 192'(exp_q.size() > 0), 192'(1));
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        m_pres   = 1;
        exp_rise = -1;
      end else if (!m_pres) begin
        cmp("rec_valid idle", 192'(if1.rec_valid), 192'(0));
      end

      if (m_pres) begin
        cmp("rec_valid held", 192'(if1.rec_valid), 192'(1));
        cmp("rec_row", 192'(if1.rec_row), 192'(cur.row));
        cmp("rec_last", 192'(if1.rec_last), 192'(cur.last));
        cmp("rec words", {if1.rec_timestamp, if1.rec_open, if1.rec_high,
                          if1.rec_low, if1.rec_close, if1.rec_volume}, cur.data);
        cmp("row_index presenting", 192'(if1.row_index), 192'(cur.row));
        cmp("col_index presenting", 192'(if1.col_index), 192'(NUM_COLS - 1));
      end else if (m_busy) begin
        d = c - fs;
        if (d > NUM_COLS - 1) d = NUM_COLS - 1;
        cmp("row_index fetching", 192'(if1.row_index), 192'(m_row));
        cmp("col_index fetching", 192'(if1.col_index), 192'(d));
      end

      // model update from the inputs of this cycle
      if (if1.abort) begin
        m_busy = 0; m_pres = 0; exp_rise = -1; exp_done = -1;
        exp_clear = c + 1;
        exp_q.delete();
      end else if (!m_busy) begin
        if (if1.start) begin
          if (int'(if1.first_row) <= int'(if1.last_row)) begin
            m_busy   = 1;
            m_row    = int'(if1.first_row);
            m_last   = int'(if1.last_row);
            fs       = c + 1;
            exp_rise = c + LAT1;
          end else begin
            exp_done = c + 1;
          end
        end
      end else if (m_pres && if1.rec_ready) begin
        m_pres = 0;
        if (m_row == m_last) begin
          m_busy   = 0;
          exp_done = c + 1;
        end else begin
          m_row    = m_row + 1;
          fs       = c + 1;
          exp_rise = c + LAT1;
        end
      end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic push_chk(input string nm, input logic [191:0] a, input logic [191:0] e);
    chk_t t;
    t.name = nm; t.act = a; t.exp = e;
    chk_q.push_back(t);
  endtask

  function automatic logic [191:0] row_words(input int r);
    return {mem[r][0], mem[r][1], mem[r][2], mem[r][3], mem[r][4], mem[r][5]};
  endfunction

  task automatic push_range(input int f, input int l);
    rec_t t;
    for (int r = f; r <= l; r++) begin
      t.row = r; t.last = (r == l); t.data = row_words(r);
      exp_q.push_back(t);
    end
  endtask

  task automatic wait_done(input int mode);
    int n;
    bit fin;
    n = 0; fin = 0;
    if (mode == 0) if1.rec_ready = 1'b1;
    while (!fin && n < 400) begin
      @(negedge clk);
      fin = if1.done;
      @(posedge clk); #1;
      if (mode == 1) if1.rec_ready = 1'($urandom_range(0, 1));
      n++;
    end
    push_chk("scan finishes", 192'(fin), 192'(1));
  endtask

  task automatic run_scan(input int f, input int l, input int mode);
    @(posedge clk); #1;
    if1.first_row = ROW_W'(f);
    if1.last_row  = ROW_W'(l);
    if1.start     = 1'b1;
    if1.rec_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    if (f <= l) push_range(f, l);
    @(posedge clk); #1;
    if1.start     = 1'b0;
    if1.first_row = ROW_W'($urandom);
    if1.last_row  = ROW_W'($urandom);
    wait_done(mode);
  endtask

  initial begin
    int n, f, l, rise, dn, nrise, rrow;
    bit pv, rlast;
    logic [191:0] w;

    rst = 1'b1;
    if1.start = 0; if1.abort = 0; if1.first_row = '0; if1.last_row = '0; if1.rec_ready = 0;
    if2.start = 0; if2.abort = 0; if2.first_row = '0; if2.last_row = '0; if2.rec_ready = 0;
    for (int r = 0; r < NUM_ROWS; r++)
      for (int cc = 0; cc < NUM_COLS; cc++) mem[r][cc] = $urandom;
    mem[5][0] = 32'h65A1B2C0; mem[5][1] = 32'h42C80000; mem[5][2] = 32'h42CA0000;
    mem[5][3] = 32'h42C60000; mem[5][4] = 32'h42C90000; mem[5][5] = 32'h4B189680;

    repeat (3) @(posedge clk);
    @(negedge clk);
    push_chk("reset row_index", 192'(if1.row_index), 192'(0));
    push_chk("reset col_index", 192'(if1.col_index), 192'(0));
    push_chk("reset busy/done/valid/last", 192'({if1.busy, if1.done, if1.rec_valid, if1.rec_last}), 192'(0));
    push_chk("reset rec_row", 192'(if1.rec_row), 192'(0));
    push_chk("reset rec words", {if1.rec_timestamp, if1.rec_open, if1.rec_high,
                                 if1.rec_low, if1.rec_close, if1.rec_volume}, 192'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    run_scan(5, 5, 0);          // single row with known words
    run_scan(1020, 1023, 0);    // top of storage
    // backpressure on the first record
    @(posedge clk); #1;
    if1.rec_ready = 0; if1.first_row = 10'd0; if1.last_row = 10'd2; if1.start = 1;
    push_range(0, 2);
    @(posedge clk); #1;
    if1.start = 0;
    n = 0;
    while (!if1.rec_valid && n < 50) begin @(negedge clk); n++; end
    push_chk("record 0 presented", 192'(if1.rec_valid), 192'(1));
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    wait_done(0);

    run_scan(10, 3, 0);         // empty range

    // abort in cycle 4 of a 0..9 scan
    @(posedge clk); #1;
    if1.first_row = 10'd0; if1.last_row = 10'd9; if1.start = 1;
    push_range(0, 9);
    @(posedge clk); #1; if1.start = 0;
    repeat (3) begin @(posedge clk); #1; end
    if1.abort = 1;
    @(posedge clk); #1; if1.abort = 0;
    repeat (12) @(posedge clk);
    #1;
    run_scan(5, 5, 0);

    // random ranges with random backpressure
    for (int s = 0; s < 10; s++) begin
      f = $urandom_range(0, NUM_ROWS - 1);
      l = f + $urandom_range(0, 3);
      if (l > NUM_ROWS - 1) l = NUM_ROWS - 1;
      if ($urandom_range(0, 5) == 0 && f > 0) l = f - 1 - $urandom_range(0, f - 1);
      run_scan(f, l, 1);
    end

    // two-cycle storage instance, with a start pulse while busy
    @(posedge clk); #1;
    if2.first_row = 10'd5; if2.last_row = 10'd5; if2.start = 1; if2.rec_ready = 1;
    rise = -1; dn = -1; nrise = 0; pv = 0; w = '0; rrow = -1; rlast = 0;
    for (int kk = 1; kk <= 30; kk++) begin
      @(posedge clk); #1;
      if2.start = (kk == 3);
      if (kk == 3) begin if2.first_row = 10'd0; if2.last_row = 10'd0; end
      @(negedge clk);
      if (if2.rec_valid && !pv) begin
        nrise++;
        if (rise < 0) begin
          rise = kk; rrow = int'(if2.rec_row); rlast = if2.rec_last;
          w = {if2.rec_timestamp, if2.rec_open, if2.rec_high,
               if2.rec_low, if2.rec_close, if2.rec_volume};
        end
      end
      pv = if2.rec_valid;
      if (if2.done && dn < 0) dn = kk;
    end
    push_chk("lat2 rec_valid cycle", 192'(rise), 192'(9));
    push_chk("lat2 rec words", w, {32'h65A1B2C0, 32'h42C80000, 32'h42CA0000,
                                   32'h42C60000, 32'h42C90000, 32'h4B189680});
    push_chk("lat2 rec_row", 192'(rrow), 192'(5));
    push_chk("lat2 rec_last", 192'(rlast), 192'(1));
    push_chk("lat2 record count", 192'(nrise), 192'(1));
    push_chk("lat2 done cycle", 192'(dn), 192'(10));
    push_chk("lat2 busy after", 192'(if2.busy), 192'(0));

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
